// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// line FSM state encoding, CAUSE bit positions and a priority helper.
package irq_controller_pkg;

  localparam logic [7:0] OFF_PEND    = 8'd0;
  localparam logic [7:0] OFF_MASK    = 8'd1;
  localparam logic [7:0] OFF_ROUTE   = 8'd2;
  localparam logic [7:0] OFF_CAUSE_A = 8'd3;
  localparam logic [7:0] OFF_CAUSE_B = 8'd4;
  localparam logic [7:0] OFF_EOI     = 8'd5;

  localparam int CAUSE_VALID = 7;
  localparam int CAUSE_TMO   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAISE   = 2'd1,
    ST_SERVICE = 2'd2
  } line_state_e;

  // Index of the lowest set bit; 0 when v is empty.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest_idx = 3'(i);
  endfunction

endpackage

// File: rtl/irq_controller_line_fsm.sv
// Per-line raise/ack/service handshake FSM with CAUSE capture.
// Ports: CLK, RESET, elig_i, ack_i, eoi_i -> raise_o, winner_o, cause_o,
// hw_clr_o. Optional IRQ_TIMEOUT_EN adds a service timeout counter.
module irq_line_fsm
  import irq_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] elig_i,
  input  logic       ack_i,
  input  logic       eoi_i,
  output logic       raise_o,
  output logic [2:0] winner_o,
  output logic [7:0] cause_o,
  output logic [7:0] hw_clr_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  line_state_e state_q, state_d;
  logic [7:0]  cause_q, cause_d;
  logic        any_elig;

`ifdef IRQ_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  assign any_elig = |elig_i;
  assign winner_o = lowest_idx(elig_i);
  assign raise_o  = (state_q == ST_RAISE);
  assign cause_o  = cause_q;

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    hw_clr_o = '0;
`ifdef IRQ_TIMEOUT_EN
    cnt_d    = '0;
`endif
    unique case (state_q)
      ST_IDLE:
        if (any_elig) state_d = ST_RAISE;
      ST_RAISE:
        if (ack_i) begin
          state_d = ST_SERVICE;
          // ACK racing an eligibility drop still enters SERVICE,
          // but with an empty CAUSE so the ISR sees no source.
          if (any_elig) begin
            cause_d  = {1'b1, 4'b0, winner_o};
            hw_clr_o = 8'd1 << winner_o;
          end else begin
            cause_d  = 8'h00;
          end
        end else if (!any_elig) begin
          state_d = ST_IDLE;
        end
      ST_SERVICE: begin
        if (eoi_i) begin
          state_d              = ST_IDLE;
          cause_d[CAUSE_VALID] = 1'b0;
        end
`ifdef IRQ_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d              = ST_IDLE;
          cause_d[CAUSE_VALID] = 1'b0;
          cause_d[CAUSE_TMO]   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge latch, mask/route, two lines.
// Ports: CLK, RESET, BUS_DATA(inout), BUS_ADDR, BUS_WE, SRC_IRQ, IRQ_RAISE,
// IRQ_ACK. Macro IRQ_TIMEOUT_EN enables the service timeout.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int         NUM_SRC        = 4,
  parameter logic [7:0] BASE_ADDR      = 8'hE0,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  output logic [1:0]         IRQ_RAISE,
  input  logic [1:0]         IRQ_ACK
);

  if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_cfg
    $error("NUM_SRC must be 1..8");
  end

  // Registers are kept 8 bits wide; bits >= NUM_SRC are held at 0.
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  logic [7:0] src_w, wdata, offs;
  logic       in_rng, wr_en, rd_req;
  logic [7:0] prev_q, pend_q, pend_d;
  logic [7:0] mask_q, mask_d, route_q, route_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_en_q;
  logic [7:0] w1c, clr, pend_set;
  logic [7:0] elig_a, elig_b, cause_a, cause_b, hclr_a, hclr_b;
  logic [2:0] win_a, win_b;
  logic       raise_a, raise_b, eoi_wr, unused_win;

  assign src_w  = 8'(SRC_IRQ);
  assign wdata  = BUS_DATA & SRC_MASK;
  // Wrapping subtraction makes the range check safe near 8'hFF.
  assign offs   = BUS_ADDR - BASE_ADDR;
  assign in_rng = (offs <= OFF_EOI);
  assign wr_en  = BUS_WE & in_rng;
  assign rd_req = ~BUS_WE & in_rng;
  assign eoi_wr = wr_en & (offs == OFF_EOI);

  assign pend_set = src_w & ~prev_q;
  assign w1c      = (wr_en && offs == OFF_PEND) ? wdata : 8'h00;
  assign clr      = w1c | hclr_a | hclr_b;
  assign pend_d   = ((pend_q & ~clr) | pend_set) & SRC_MASK;
  assign mask_d   = (wr_en && offs == OFF_MASK) ? wdata : mask_q;
  assign route_d  = (wr_en && offs == OFF_ROUTE) ? wdata : route_q;

  assign elig_a = pend_q & mask_q & ~route_q;
  assign elig_b = pend_q & mask_q & route_q;

  always_comb begin
    rd_data_d = 8'h00;
    case (offs)
      OFF_PEND:    rd_data_d = pend_q;
      OFF_MASK:    rd_data_d = mask_q;
      OFF_ROUTE:   rd_data_d = route_q;
      OFF_CAUSE_A: rd_data_d = cause_a;
      OFF_CAUSE_B: rd_data_d = cause_b;
      default:     rd_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q    <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      route_q   <= '0;
      rd_data_q <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      prev_q    <= src_w;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      route_q   <= route_d;
      rd_data_q <= rd_data_d;
      rd_en_q   <= rd_req;
    end
  end

  assign BUS_DATA  = rd_en_q ? rd_data_q : 8'hzz;
  assign IRQ_RAISE = {raise_b, raise_a};

  // Winner is already encoded in CAUSE; the raw index is informational.
  assign unused_win = ^{win_a, win_b};

  irq_line_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_line_a (
    .CLK      (CLK),
    .RESET    (RESET),
    .elig_i   (elig_a),
    .ack_i    (IRQ_ACK[0]),
    .eoi_i    (eoi_wr & ~BUS_DATA[0]),
    .raise_o  (raise_a),
    .winner_o (win_a),
    .cause_o  (cause_a),
    .hw_clr_o (hclr_a)
  );

  irq_line_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_line_b (
    .CLK      (CLK),
    .RESET    (RESET),
    .elig_i   (elig_b),
    .ack_i    (IRQ_ACK[1]),
    .eoi_i    (eoi_wr & BUS_DATA[0]),
    .raise_o  (raise_b),
    .winner_o (win_b),
    .cause_o  (cause_b),
    .hw_clr_o (hclr_b)
  );

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
// Read expectations go through a scoreboard queue; undriven bus reads 8'hFF.
module tb_irq_controller;

  localparam logic [7:0] BASE = 8'hE0;
  localparam logic [7:0] BZ   = 8'hFF;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  wire  [7:0] bus;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       we = 1'b0;
  logic [3:0] src = 4'h0;
  logic [1:0] raise;
  logic [1:0] ack = 2'b00;

  int errors = 0;
  int checks = 0;
  logic [7:0] expq[$];

  assign bus = drv_en ? drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  always #5 CLK = ~CLK;

  irq_controller #(
    .NUM_SRC(4), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(10)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUS_DATA  (bus),
    .BUS_ADDR  (addr),
    .BUS_WE    (we),
    .SRC_IRQ   (src),
    .IRQ_RAISE (raise),
    .IRQ_ACK   (ack)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    addr = BASE + off; we = 1'b1; drv = d; drv_en = 1'b1;
    @(negedge CLK);
    addr = 8'h00; we = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [7:0] exp,
                    input string tag);
    addr = BASE + off; we = 1'b0;
    expq.push_back(exp);
    #1 chk({tag, "_pre"}, bus, BZ);
    @(negedge CLK);
    addr = 8'h00;
    chk(tag, bus, expq.pop_front());
    @(negedge CLK);
    chk({tag, "_z"}, bus, BZ);
  endtask

  task automatic pulse(input logic [3:0] s);
    src = s;
    @(negedge CLK);
    src = 4'h0;
  endtask

  task automatic do_ack(input logic [1:0] a);
    ack = a;
    @(negedge CLK);
    ack = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    RESET = 1'b0;
    chk("rst_raise", {6'b0, raise}, 8'h00);
    chk("rst_bus", bus, BZ);
    rd(OFF(0), 8'h00, "rst_pend");
    rd(OFF(1), 8'h00, "rst_mask");
    rd(OFF(2), 8'h00, "rst_route");
    rd(OFF(3), 8'h00, "rst_cause_a");
    rd(OFF(4), 8'h00, "rst_cause_b");
    rd(OFF(5), 8'h00, "rst_eoi");

    // single source on line A
    wr(OFF(1), 8'h01);
    pulse(4'b0001);
    chk("t1_lat1", {6'b0, raise}, 8'h00);
    cyc(1);
    chk("t1_raise", {6'b0, raise}, 8'h01);
    do_ack(2'b01);
    chk("t1_ack_low", {6'b0, raise}, 8'h00);
    rd(OFF(3), 8'h80, "t1_cause_a");
    rd(OFF(0), 8'h00, "t1_pend");
    wr(OFF(5), 8'h00);
    rd(OFF(3), 8'h00, "t1_eoi_cause");

    // both lines at once
    wr(OFF(1), 8'h0F);
    wr(OFF(2), 8'h0C);
    pulse(4'b1010);
    cyc(1);
    chk("t2_raise", {6'b0, raise}, 8'h03);
    do_ack(2'b11);
    chk("t2_ack_low", {6'b0, raise}, 8'h00);
    rd(OFF(3), 8'h81, "t2_cause_a");
    rd(OFF(4), 8'h83, "t2_cause_b");
    rd(OFF(0), 8'h00, "t2_pend");
    wr(OFF(5), 8'h00);
    wr(OFF(5), 8'h01);
    rd(OFF(3), 8'h01, "t2_eoi_a");
    rd(OFF(4), 8'h03, "t2_eoi_b");

    // priority and re-raise after EOI
    wr(OFF(2), 8'h00);
    pulse(4'b0110);
    cyc(1);
    chk("t3_raise", {6'b0, raise}, 8'h01);
    do_ack(2'b01);
    rd(OFF(3), 8'h81, "t3_cause_1");
    rd(OFF(0), 8'h04, "t3_pend_left");
    pulse(4'b0100);
    rd(OFF(0), 8'h04, "t3_pend_svc");
    chk("t3_svc_low", {6'b0, raise}, 8'h00);
    wr(OFF(5), 8'h00);
    cyc(1);
    chk("t3_reraise", {6'b0, raise}, 8'h01);
    do_ack(2'b01);
    rd(OFF(3), 8'h82, "t3_cause_2");
    rd(OFF(0), 8'h00, "t3_pend_done");
    wr(OFF(5), 8'h00);

    // withdraw while raised, W1C vs set, stray ACK
    wr(OFF(1), 8'h01);
    pulse(4'b0001);
    cyc(1);
    chk("t4_raise", {6'b0, raise}, 8'h01);
    wr(OFF(1), 8'h00);
    cyc(1);
    chk("t4_drop", {6'b0, raise}, 8'h00);
    rd(OFF(3), 8'h02, "t4_cause_keep");
    rd(OFF(0), 8'h01, "t4_pend_keep");
    wr(OFF(0), 8'h01);
    rd(OFF(0), 8'h00, "t4_w1c");
    addr = BASE; we = 1'b1; drv = 8'h01; drv_en = 1'b1; src = 4'b0001;
    @(negedge CLK);
    addr = 8'h00; we = 1'b0; drv_en = 1'b0; src = 4'h0;
    rd(OFF(0), 8'h01, "t4_set_wins");
    do_ack(2'b01);
    rd(OFF(3), 8'h02, "t4_idle_ack");
    wr(OFF(0), 8'h0F);

    // read timing and out-of-range address
    wr(OFF(1), 8'h05);
    rd(OFF(1), 8'h05, "t5_mask");
    addr = BASE + 8'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t5_oor", bus, BZ);
    end
    addr = 8'h00;
    cyc(1);

`ifdef IRQ_TIMEOUT_EN
    wr(OFF(1), 8'h01);
    pulse(4'b0001);
    cyc(1);
    do_ack(2'b01);
    rd(OFF(3), 8'h80, "to_svc");
    cyc(10);
    rd(OFF(3), 8'h40, "to_cause");
    chk("to_raise", {6'b0, raise}, 8'h00);
    wr(OFF(1), 8'h05);
`endif

    // reset during RAISE
    pulse(4'b0001);
    cyc(1);
    chk("t6_raise", {6'b0, raise}, 8'h01);
    RESET = 1'b1;
    @(negedge CLK);
    chk("t6_rst_raise", {6'b0, raise}, 8'h00);
    chk("t6_rst_bus", bus, BZ);
    RESET = 1'b0;
    rd(OFF(0), 8'h00, "t6_pend");
    rd(OFF(1), 8'h00, "t6_mask");
    rd(OFF(3), 8'h00, "t6_cause_a");
    chk("t6_idle", {6'b0, raise}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [7:0] OFF(input int n);
    return 8'(n);
  endfunction

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller between up to 8 peripheral interrupt sources and the processor's two interrupt lines (A = raise/ack bit 0, B = bit 1).
- Latches source edges into a pending register, masks and routes each source to line A or B, and picks the lowest-index source per line.
- Runs the raise/ack handshake for each line and holds the line in service until software writes end-of-interrupt (EOI).
- Sits on the shared 8-bit data bus; ISRs read CAUSE to identify the source.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8)
BASE_ADDR, 8'hE0, bus address of register 0; block decodes BASE_ADDR..BASE_ADDR+5
TIMEOUT_CYCLES, 255, service timeout in CLK cycles (used only with IRQ_TIMEOUT_EN)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
BUS_DATA  inout  8  shared data bus; driven only during a registered read
BUS_ADDR  in  8  bus address from processor
BUS_WE  in  1  bus write enable from processor
SRC_IRQ  in  NUM_SRC  peripheral requests; rising edge = event
IRQ_RAISE  out  2  interrupt request to processor, [0]=A, [1]=B
IRQ_ACK  in  2  one-cycle acknowledge from processor, [0]=A, [1]=B

Behaviour:
- Reset is RESET, synchronous, active-high; clock is CLK. Reset values: IRQ_RAISE=0, BUS_DATA=Z, PENDING=0, MASK=0, ROUTE=0, CAUSE_A=CAUSE_B=0, both FSMs IDLE. Reset mid-handshake abandons service with no ACK required.
- Registers (offset from BASE_ADDR):
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: r/w; 1 = enabled.
  - 2 ROUTE: r/w; bit i 0 = line A, 1 = line B.
  - 3 CAUSE_A: read only.
  - 4 CAUSE_B: read only.
  - 5 EOI: write only; data[0] selects line; reads return 0.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Writes are captured on the clock edge where BUS_WE=1 and the address is in range.
- Reads: when BUS_WE=0 and the address is in range, the data and drive enable are registered. BUS_DATA is driven for exactly the following cycle, then returns to Z. This gives a 1-cycle read latency.
- Edge detect: a previous-value register per source. pend_set[i] = SRC_IRQ[i] & ~prev[i].
- Pending update per cycle: PENDING = (PENDING & ~clr) | pend_set. clr combines the W1C write and the hardware clear on ACK. Set wins over a clear in the same cycle.
- eligible_A = PENDING & MASK & ~ROUTE; eligible_B = PENDING & MASK & ROUTE. Winner is the lowest set index.
- Per-line FSM, two identical instances:
  - IDLE: if eligible nonzero -> RAISE. IRQ_RAISE registered; high only while in RAISE.
  - RAISE: on ACK, latch CAUSE = {1'b1, 4'b0, winner[2:0]}, clear the winner's PENDING bit, go to SERVICE. If eligible drops to 0 before ACK (mask, route or W1C change), go to IDLE, CAUSE unchanged. If ACK arrives with eligible=0 in the same cycle, CAUSE = 8'h00 and go to SERVICE.
  - SERVICE: raise low. A write of EOI for this line -> IDLE and clears CAUSE bit 7. Sources keep latching into PENDING meanwhile.
- An EOI for a line not in SERVICE is ignored.
- Lines A and B run independently and may both be raised; the processor gives A priority.
- ACK while in IDLE or SERVICE is ignored.
- Minimum latency from source edge to IRQ_RAISE high is 2 cycles: one for the pending register, one for the FSM/raise register.

Optional Feature:
- IRQ_TIMEOUT_EN defined: a per-line counter runs in SERVICE. If no EOI arrives within TIMEOUT_CYCLES cycles, the FSM forces IDLE, clears CAUSE bit 7 and sets CAUSE bit 6 (timeout flag, cleared at the next ACK latch).
- IRQ_TIMEOUT_EN undefined: no counter, and SERVICE waits indefinitely for EOI.

Decomposition:
- Shared package holds:
  - register offset constants: PEND=0, MASK=1, ROUTE=2, CAUSE_A=3, CAUSE_B=4, EOI=5;
  - FSM state encodings: IDLE, RAISE, SERVICE;
  - CAUSE bit positions: VALID=7, TIMEOUT=6.
- One sub-module, irq_line_fsm, instantiated twice. Inputs: eligible vector, ACK, EOI strobe. Outputs: raise, winner index, cause, hardware-clear vector.

Test Plan:
- MASK=0x01, ROUTE=0, pulse SRC_IRQ[0] -> IRQ_RAISE[0] high 2 cycles later; ACK[0] -> raise low, CAUSE_A reads 0x80, PENDING bit0 = 0.
- MASK=0x0F, ROUTE=0x0C, edges on sources 1 and 3 in the same cycle -> both IRQ_RAISE bits high; ACK both -> CAUSE_A=0x81, CAUSE_B=0x83.
- Sources 2 and 1 pending on A -> first ACK gives CAUSE_A=0x81. Source 2 edge during SERVICE, then EOI data=0x00 -> re-raise; ACK -> CAUSE_A=0x82.
- Line A in RAISE, write MASK=0 -> raise drops next cycle, FSM IDLE, CAUSE_A unchanged. W1C write 0x01 in the same cycle as a source-0 edge -> PENDING bit0 stays 1.
- Read BASE_ADDR+1 after MASK=0x05 -> BUS_DATA=0x05 for exactly one cycle after the address cycle, Z otherwise. Address BASE_ADDR+6 -> never driven.
- IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, ACK with no EOI -> IDLE after 10 cycles, CAUSE_A=0x40. Assert RESET during RAISE -> all outputs and registers at reset values next cycle.
